// File: rtl/vga_timing_pkg.sv
// Shared timing-set type, reset-default 1024x768 raster and legality helper for vga_timing_gen.
package vga_timing_pkg;

  localparam int TM_CNT_W = 12;
  localparam logic [TM_CNT_W+1:0] TM_MAX_TOTAL = (TM_CNT_W+2)'(1) << TM_CNT_W;

  typedef struct packed {
    logic [TM_CNT_W-1:0] h_active;
    logic [TM_CNT_W-1:0] h_fp;
    logic [TM_CNT_W-1:0] h_sync;
    logic [TM_CNT_W-1:0] h_bp;
    logic [TM_CNT_W-1:0] v_active;
    logic [TM_CNT_W-1:0] v_fp;
    logic [TM_CNT_W-1:0] v_sync;
    logic [TM_CNT_W-1:0] v_bp;
    logic                hs_pol;
    logic                vs_pol;
  } timing_t;

  localparam timing_t TIMING_DEFAULT = '{
    h_active: TM_CNT_W'(1024), h_fp: TM_CNT_W'(24), h_sync: TM_CNT_W'(136), h_bp: TM_CNT_W'(160),
    v_active: TM_CNT_W'(768),  v_fp: TM_CNT_W'(3),  v_sync: TM_CNT_W'(6),   v_bp: TM_CNT_W'(29),
    hs_pol: 1'b0, vs_pol: 1'b0
  };

  typedef enum logic {ST_IDLE, ST_PEND} cfg_state_t;

  // Totals are formed two bits wider so a full 2^CNT_W line/frame cannot overflow.
  function automatic logic timing_legal(input timing_t t);
    logic [TM_CNT_W+1:0] h_tot;
    logic [TM_CNT_W+1:0] v_tot;
    h_tot = {2'b00, t.h_active} + {2'b00, t.h_fp} + {2'b00, t.h_sync} + {2'b00, t.h_bp};
    v_tot = {2'b00, t.v_active} + {2'b00, t.v_fp} + {2'b00, t.v_sync} + {2'b00, t.v_bp};
    return (t.h_active != '0) && (t.h_fp != '0) && (t.h_sync != '0) && (t.h_bp != '0) &&
           (t.v_active != '0) && (t.v_fp != '0) && (t.v_sync != '0) && (t.v_bp != '0) &&
           (h_tot <= TM_MAX_TOTAL) && (v_tot <= TM_MAX_TOTAL);
  endfunction

endpackage

// File: rtl/vga_timing_gen_axis.sv
// One raster axis: position counter with wrap, active/sync decode and last-position flag.
module vga_axis_gen #(
  parameter int CNT_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_step,
  input  logic [CNT_W-1:0] i_active,
  input  logic [CNT_W-1:0] i_fp,
  input  logic [CNT_W-1:0] i_sync,
  input  logic [CNT_W-1:0] i_bp,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_active,
  output logic             o_sync,
  output logic             o_last
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W+1:0] w_cnt_ext;
  logic [CNT_W+1:0] w_sync_start;
  logic [CNT_W+1:0] w_sync_end;
  logic [CNT_W+1:0] w_total;

  assign w_cnt_ext    = {2'b00, r_cnt};
  assign w_sync_start = {2'b00, i_active} + {2'b00, i_fp};
  assign w_sync_end   = w_sync_start + {2'b00, i_sync};
  assign w_total      = w_sync_end + {2'b00, i_bp};

  assign o_cnt    = r_cnt;
  assign o_active = w_cnt_ext < {2'b00, i_active};
  assign o_sync   = (w_cnt_ext >= w_sync_start) && (w_cnt_ext < w_sync_end);
  assign o_last   = w_cnt_ext == (w_total - (CNT_W+2)'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_step) begin
      r_cnt <= o_last ? '0 : r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Programmable VGA/DVI raster generator; new timing sets take effect only at a frame boundary.
// Optional acceptance-time legality check: define VGA_TIMING_CFG_CHECK_EN.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int      CNT_W      = TM_CNT_W,
  parameter timing_t DEF_TIMING = TIMING_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pix_en,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_h_active,
  input  logic [CNT_W-1:0] cfg_h_fp,
  input  logic [CNT_W-1:0] cfg_h_sync,
  input  logic [CNT_W-1:0] cfg_h_bp,
  input  logic [CNT_W-1:0] cfg_v_active,
  input  logic [CNT_W-1:0] cfg_v_fp,
  input  logic [CNT_W-1:0] cfg_v_sync,
  input  logic [CNT_W-1:0] cfg_v_bp,
  input  logic             cfg_hs_pol,
  input  logic             cfg_vs_pol,
  output logic             cfg_err,
  output logic             h_pulse,
  output logic             v_pulse,
  output logic             video_valid,
  output logic [CNT_W-1:0] x_pos,
  output logic [CNT_W-1:0] y_pos,
  output logic             line_start,
  output logic             frame_start
);

  cfg_state_t       r_state;
  cfg_state_t       w_state_nxt;
  timing_t          r_work;
  timing_t          r_pend;
  timing_t          w_offer;
  logic             w_accept;
  logic             w_legal;
  logic             w_apply;
  logic             w_frame_end;
  logic [CNT_W-1:0] w_h_cnt;
  logic [CNT_W-1:0] w_v_cnt;
  logic             w_h_active, w_h_sync, w_h_last;
  logic             w_v_active, w_v_sync, w_v_last;
  logic             w_active;
  logic             r_h_pulse, r_v_pulse, r_video_valid, r_line_start, r_frame_start;
  logic [CNT_W-1:0] r_x_pos, r_y_pos;

  assign w_offer = '{
    h_active: cfg_h_active, h_fp: cfg_h_fp, h_sync: cfg_h_sync, h_bp: cfg_h_bp,
    v_active: cfg_v_active, v_fp: cfg_v_fp, v_sync: cfg_v_sync, v_bp: cfg_v_bp,
    hs_pol: cfg_hs_pol, vs_pol: cfg_vs_pol
  };

  assign w_accept = cfg_valid & cfg_ready;

`ifdef VGA_TIMING_CFG_CHECK_EN
  logic r_cfg_err;

  assign w_legal = timing_legal(w_offer);
  assign cfg_err = r_cfg_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cfg_err <= 1'b0;
    end else begin
      r_cfg_err <= w_accept & ~w_legal;
    end
  end
`else
  assign w_legal = 1'b1;
  assign cfg_err = 1'b0;
`endif

  vga_axis_gen #(.CNT_W(CNT_W)) u_h_axis (
    .clk      (clk),
    .rst      (rst),
    .i_step   (pix_en),
    .i_active (r_work.h_active),
    .i_fp     (r_work.h_fp),
    .i_sync   (r_work.h_sync),
    .i_bp     (r_work.h_bp),
    .o_cnt    (w_h_cnt),
    .o_active (w_h_active),
    .o_sync   (w_h_sync),
    .o_last   (w_h_last)
  );

  vga_axis_gen #(.CNT_W(CNT_W)) u_v_axis (
    .clk      (clk),
    .rst      (rst),
    .i_step   (pix_en & w_h_last),
    .i_active (r_work.v_active),
    .i_fp     (r_work.v_fp),
    .i_sync   (r_work.v_sync),
    .i_bp     (r_work.v_bp),
    .o_cnt    (w_v_cnt),
    .o_active (w_v_active),
    .o_sync   (w_v_sync),
    .o_last   (w_v_last)
  );

  assign w_frame_end = pix_en & w_h_last & w_v_last;
  assign w_active    = w_h_active & w_v_active;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept && w_legal) w_state_nxt = ST_PEND;
      ST_PEND: if (w_frame_end)         w_state_nxt = ST_IDLE;
      default:                          w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    cfg_ready = (r_state == ST_IDLE);
    w_apply   = (r_state == ST_PEND) && w_frame_end;
  end

  // Pending set is only ever read after a capture, so it carries no reset.
  always_ff @(posedge clk) begin
    if (w_accept && w_legal) begin
      r_pend <= w_offer;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_work <= DEF_TIMING;
    end else if (w_apply) begin
      r_work <= r_pend;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_h_pulse     <= ~DEF_TIMING.hs_pol;
      r_v_pulse     <= ~DEF_TIMING.vs_pol;
      r_video_valid <= 1'b0;
      r_x_pos       <= '0;
      r_y_pos       <= '0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else if (pix_en) begin
      r_h_pulse     <= w_h_sync ? r_work.hs_pol : ~r_work.hs_pol;
      r_v_pulse     <= w_v_sync ? r_work.vs_pol : ~r_work.vs_pol;
      r_video_valid <= w_active;
      r_x_pos       <= w_active ? w_h_cnt : '0;
      r_y_pos       <= w_active ? w_v_cnt : '0;
      r_line_start  <= w_active && (w_h_cnt == '0);
      r_frame_start <= w_active && (w_h_cnt == '0) && (w_v_cnt == '0);
    end
  end

  assign h_pulse     = r_h_pulse;
  assign v_pulse     = r_v_pulse;
  assign video_valid = r_video_valid;
  assign x_pos       = r_x_pos;
  assign y_pos       = r_y_pos;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;

endmodule
